// File: rtl/serial_add_pkg.sv
// Shared state encoding for the bit-serial adder sequencer.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/full_add_bit.sv
// One-bit full adder cell; the only arithmetic in the serial adder.
module full_add_bit (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and majority carry
  always_comb begin
    sum  = in1 ^ in2 ^ cin;
    cout = (in1 & in2) | (in1 & cin) | (in2 & cin);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: reuses one full-adder cell over WIDTH cycles, LSB first.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               s_bit;
  logic               c_bit;

  full_add_bit u_fa (
    .in1  (a_sh_q[0]),
    .in2  (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (s_bit),
    .cout (c_bit)
  );

  // Next-state, datapath shifting and registered output values
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = {s_bit, sum_q[WIDTH-1:1]};
        carry_d = c_bit;
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          cout_d  = c_bit;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous abort
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int checks;
  int errors;
  int done_cnt8;
  int done_cnt16;
  bit done8_prev;
  bit done16_prev;

  logic [32:0] q8[$];
  logic [32:0] q16[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .busy      (busy8),
    .done      (done8),
    .sum       (sum8),
    .cout      (cout8)
  );

  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .start     (start16),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
    .busy      (busy16),
    .done      (done16),
    .sum       (sum16),
    .cout      (cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard for the 8-bit instance: pop and compare on every done pulse
  always @(negedge clk) begin
    if (rst_n && done8) begin
      done_cnt8++;
      chk("done_width8", 64'(done8_prev), 64'd0);
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: got done with no pending add (t=%0t)", $time);
      end else begin
        chk("result8", 64'({cout8, sum8}), 64'(q8.pop_front()));
      end
    end
    done8_prev = rst_n && done8;
  end

  // Scoreboard for the 16-bit instance
  always @(negedge clk) begin
    if (rst_n && done16) begin
      done_cnt16++;
      chk("done_width16", 64'(done16_prev), 64'd0);
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done16: got done with no pending add (t=%0t)", $time);
      end else begin
        chk("result16", 64'({cout16, sum16}), 64'(q16.pop_front()));
      end
    end
    done16_prev = rst_n && done16;
  end

  // One 8-bit addition from IDLE; done must appear WIDTH edges after the accepting edge
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [8:0] exp);
    int n;
    bit busy_ok;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(33'(exp));
    @(negedge clk);
    start8 = 1'b0;
    chk("busy_after_accept8", 64'(busy8), 64'd1);
    n = 0;
    busy_ok = 1'b1;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
      if (!busy8) busy_ok = 1'b0;
    end
    chk("done_offset8", 64'(n), 64'd8);
    chk("busy_through_run8", 64'(busy_ok), 64'd1);
    @(negedge clk);
    chk("busy_low_after8", 64'(busy8), 64'd0);
    chk("done_low_after8", 64'(done8), 64'd0);
    chk("result_held8", 64'({cout8, sum8}), 64'(exp));
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c);
    int n;
    logic [16:0] exp;
    exp = {1'b0, a} + {1'b0, b} + 17'(c);
    @(negedge clk);
    a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
    q16.push_back(33'(exp));
    @(negedge clk);
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_offset16", 64'(n), 64'd16);
    @(negedge clk);
    chk("busy_low_after16", 64'(busy16), 64'd0);
  endtask

  initial begin
    int n;
    int base;
    logic [7:0] ra, rb;
    logic       rc;

    checks = 0; errors = 0; done_cnt8 = 0; done_cnt16 = 0;
    done8_prev = 1'b0; done16_prev = 1'b0;
    start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
    start16 = 0; a16 = '0; b16 = '0; cin16 = 0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_sum", 64'(sum8), 64'd0);
    chk("rst_cout", 64'(cout8), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum});

    // start held high: accepted every WIDTH+2 edges; mid-RUN operand changes ignored
    base = done_cnt8;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(33'h3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a8 = 8'($urandom()); b8 = 8'($urandom()); cin8 = 1'b1;
      n = 0;
      while (!done8 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("held_done_offset", 64'(n), 64'd8);
      a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
      if (k < 2) q8.push_back(33'h3);
      else start8 = 1'b0;
      @(negedge clk);
      chk("held_idle_gap", 64'(busy8), 64'd0);
    end
    @(negedge clk);
    chk("held_stopped", 64'(busy8), 64'd0);
    chk("held_done_count", 64'(done_cnt8 - base), 64'd3);

    // start pulse during RUN with other operands is ignored
    base = done_cnt8;
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(33'h33);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'hEE; b8 = 8'hEE; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (20) @(negedge clk);
    chk("ignored_start_done_count", 64'(done_cnt8 - base), 64'd1);
    chk("ignored_start_sum_held", 64'({cout8, sum8}), 64'h33);

    // Asynchronous reset 4 cycles into RUN aborts with no done
    base = done_cnt8;
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_sum", 64'(sum8), 64'd0);
    chk("abort_cout", 64'(cout8), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt8 - base), 64'd0);
    run8(8'h10, 8'h20, 1'b0, 9'h030);

    // Random sweep, both widths
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom()); rb = 8'($urandom()); rc = 1'($urandom());
      run8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 9'(rc));
    end
    for (int i = 0; i < 1000; i++)
      run16(16'($urandom()), 16'($urandom()), 1'($urandom()));

    repeat (5) @(negedge clk);
    chk("queue8_drained", 64'(q8.size()), 64'd0);
    chk("queue16_drained", 64'(q16.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
